arb_mux_n: RTL and testbench
============================

Name: arb_mux_n

Overview:
- N-input, clocked successor to the two-input priority mux; merges NUM_IN valid/ready input streams onto one output stream.
- Arbitration mode is selectable by parameter: fixed priority (index 0 highest) or round-robin.
- Optional packet lock keeps the grant on one source until its last flit.
- A 2-entry output skid buffer decouples out_ready from in_ready. Sits in front of the PE output port, where several producers share one link.

Parameters:
- WIDTH, 8, data bits per flit.
- NUM_IN, 4, number of input streams (2..16).
- MODE, 0, 0 = fixed priority (index 0 highest); 1 = round-robin.
- LOCK_PKT, 1, 1 = grant held from first flit to in_last flit; 0 = per-flit arbitration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-input valid.
- in_last  in  NUM_IN  per-input end-of-packet marker; ignored when LOCK_PKT=0.
- in_ready  out  NUM_IN  per-input ready; one-hot or zero.
- out_data  out  WIDTH  head-of-buffer data.
- out_src  out  $clog2(NUM_IN)  index of the source of the head flit.
- out_last  out  1  in_last of the head flit.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid=0, out_data=0, out_src=0, out_last=0.
  - Buffer count=0, rr_ptr=0, lock=0, lock_idx=0.
  - in_ready=0 while rst is high.
- Transfer rules:
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
- Space:
  - space = (count < 2), computed from the registered count only.
  - in_ready has no combinational path from out_ready.
  - At count==2 no input is accepted, even if a pop occurs that cycle.
- Grant (combinational, only when space=1; in_ready=0 for all inputs otherwise):
  - If lock=1: grant lock_idx only, and only if in_valid[lock_idx]. Other inputs wait even if valid.
  - Else if MODE=0: lowest-index valid input wins.
  - Else if MODE=1: the first valid input searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - At most one in_ready bit is high.
- Lock FSM (only when LOCK_PKT=1):
  - States: IDLE (lock=0) and LOCKED (lock=1).
  - IDLE -> LOCKED on an accepted flit with in_last=0; lock_idx is set to that source.
  - LOCKED -> IDLE on an accepted flit from lock_idx with in_last=1.
  - A single-flit packet (in_last=1 on first flit) stays in IDLE.
  - When LOCK_PKT=0, lock stays 0 permanently.
- Round-robin pointer:
  - Updated only on acceptance of a packet-ending flit from source g: rr_ptr = (g+1) mod NUM_IN.
  - A packet-ending flit is in_last=1, or any flit when LOCK_PKT=0.
  - rr_ptr == NUM_IN-1 wraps to 0.
  - Unchanged on cycles with no acceptance.
- Buffer:
  - 2-entry FIFO of {data, src, last}.
  - Latency: a flit accepted at edge k appears on out_* after edge k (one-cycle latency).
  - Order is preserved.
  - Simultaneous push and pop at count=1 leaves count=1; sustained throughput is 1 flit/cycle.
  - Pop at count=0 is impossible, since out_valid=0.
- Boundary cases:
  - Back-pressure: out_ready low forever gives exactly 2 flits buffered, then all in_ready=0.
  - No valid inputs: no state change.
  - in_valid dropping during lock: grant is held; no other source is served.
  - Reset mid-packet clears the lock and buffer immediately; buffered flits are discarded.
- Inputs are expected to hold data/valid until accepted; this is not checked.

Decomposition:
- Package arb_mux_pkg:
  - typedef arb_mode_e {ARB_FIXED=0, ARB_RR=1}.
  - Function first_from(valid, start) returning the index of the first set bit starting at start with wrap. It is used for both modes (start=0 for fixed).
  - Constant BUF_DEPTH=2.
- Sub-module arb_skid_buf: 2-entry FIFO with push/pop/count, parameterised on payload width. Arbiter and lock FSM stay in the top.

Test Plan:
- Fixed priority, MODE=0, LOCK_PKT=0, NUM_IN=4, out_ready=1, all in_valid held 1 with in_data = 8'h10, 8'h21, 8'h32, 8'h43 -> out_src=0 every cycle, out_data=8'h10; inputs 1-3 starve.
- Round-robin, MODE=1, LOCK_PKT=0, all four valid continuously -> out_src sequence 0,1,2,3,0,1 on consecutive cycles after the first-flit latency of 1 cycle.
- Packet lock, MODE=1, LOCK_PKT=1:
  - Stimulus: input 2 sends 3 flits A0,A1,A2 (last on A2) while input 0 is valid throughout.
  - Response: out_src=2 for three flits, then 0; rr_ptr=3 after A2.
  - A gap in input 2's valid mid-packet stalls the output; no flit from 0 is interleaved.
- Back-pressure: out_ready=0, inputs 0 and 1 valid:
  - After 2 accepts, in_ready=4'b0000 and out_valid=1.
  - Raising out_ready gives one pop per cycle, with data order matching acceptance order.
- Wrap and single-flit packets, MODE=1, NUM_IN=4: only input 3 valid, with in_last=1 -> rr_ptr returns to 0; next the input 0 and 3 requests grant 0 first.
- Reset mid-operation: assert rst for 1 ns between edges while LOCKED with count=2:
  - Immediately out_valid=0 and in_ready=0.
  - After release, the first grant uses rr_ptr=0 with lock cleared.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the N-input arbitrating stream mux.
package arb_mux_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int BUF_DEPTH = 2;
    localparam int MAX_IN    = 16;

    // Index of the first set bit in valid[0..n-1], searching from start with wrap.
    // Returns start when nothing is set; callers gate the result with |valid.
    function automatic int first_from(input logic [MAX_IN-1:0] valid,
                                      input int start,
                                      input int n);
        int idx;
        int res;
        res = start;
        for (int k = MAX_IN - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (start + k) % n;
                if (valid[idx[3:0]]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// Two-entry FIFO decoupling the arbiter from the output consumer.
module arb_skid_buf
    import arb_mux_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [PW-1:0] i_data,
    output logic [PW-1:0] o_data,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [PW-1:0] r_mem [BUF_DEPTH];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count < 2'(BUF_DEPTH));
    assign w_pop  = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/arb_mux_n.sv
// NUM_IN-way valid/ready stream arbiter (fixed or round-robin) with optional
// packet lock, feeding a 2-entry output buffer.
//   state     | meaning
//   ST_IDLE   | no packet in flight; arbitrate among all valid inputs
//   ST_LOCKED | mid-packet; only r_lock_idx may be granted until its last flit
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_IN   = 4,
    parameter int MODE     = 0,
    parameter int LOCK_PKT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN-1:0]         in_last,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_IN)-1:0] out_src,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int IW = $clog2(NUM_IN);
    localparam int PW = WIDTH + IW + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e   r_state;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_rr_ptr;

    logic [1:0]    w_count;
    logic          w_space;
    int            w_start;
    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_grant_idx;
    logic          w_grant_vld;
    logic          w_last_in;
    logic          w_pkt_end;
    logic [PW-1:0] w_push_data;
    logic [PW-1:0] w_head;

    // Space comes from the registered count only, so in_ready never sees out_ready.
    assign w_space = (w_count < 2'(BUF_DEPTH));
    assign w_start = (MODE == int'(ARB_RR)) ? int'(r_rr_ptr) : 0;
    assign w_pick  = IW'(first_from(MAX_IN'(in_valid), w_start, NUM_IN));

    always_comb begin
        w_grant_idx = w_pick;
        w_grant_vld = 1'b0;
        if (w_space && !rst) begin
            if (r_state == ST_LOCKED) begin
                w_grant_idx = r_lock_idx;
                w_grant_vld = in_valid[r_lock_idx];
            end else begin
                w_grant_vld = |in_valid;
            end
        end
    end

    assign in_ready    = w_grant_vld ? (NUM_IN'(1) << w_grant_idx) : '0;
    assign w_last_in   = in_last[w_grant_idx];
    assign w_pkt_end   = (LOCK_PKT != 0) ? w_last_in : 1'b1;
    assign w_push_data = {in_data[w_grant_idx*WIDTH +: WIDTH], w_grant_idx, w_last_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else if (w_grant_vld) begin
            if (LOCK_PKT != 0) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_last_in) begin
                            r_state    <= ST_LOCKED;
                            r_lock_idx <= w_grant_idx;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_last_in) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (w_pkt_end) begin
                r_rr_ptr <= (w_grant_idx == IW'(NUM_IN - 1)) ? '0 : w_grant_idx + IW'(1);
            end
        end
    end

    arb_skid_buf #(
        .PW(PW)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_grant_vld),
        .i_pop  (out_ready),
        .i_data (w_push_data),
        .o_data (w_head),
        .o_valid(out_valid),
        .o_count(w_count)
    );

    assign out_data = w_head[PW-1 -: WIDTH];
    assign out_src  = w_head[IW:1];
    assign out_last = w_head[0];

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench: fixed-priority per-flit instance and round-robin packet-lock instance.
module tb_arb_mux_n;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] f_in_data, a_in_data;
    logic [3:0]  f_in_valid, a_in_valid;
    logic [3:0]  f_in_last, a_in_last;
    logic [3:0]  f_in_ready, a_in_ready;
    logic [7:0]  f_out_data, a_out_data;
    logic [1:0]  f_out_src, a_out_src;
    logic        f_out_last, a_out_last;
    logic        f_out_valid, a_out_valid;
    logic        f_out_ready, a_out_ready;

    int    checks = 0;
    int    errors = 0;
    flit_t q_fx[$];
    flit_t q_rr[$];
    flit_t m_fx_exp, m_rr_exp, m_got;

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(8), .NUM_IN(4), .MODE(0), .LOCK_PKT(0)) u_fix (
        .clk(clk), .rst(rst),
        .in_data(f_in_data), .in_valid(f_in_valid), .in_last(f_in_last), .in_ready(f_in_ready),
        .out_data(f_out_data), .out_src(f_out_src), .out_last(f_out_last),
        .out_valid(f_out_valid), .out_ready(f_out_ready)
    );

    arb_mux_n #(.WIDTH(8), .NUM_IN(4), .MODE(1), .LOCK_PKT(1)) u_rr (
        .clk(clk), .rst(rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_src(a_out_src), .out_last(a_out_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rr(input logic [1:0] s, input logic [7:0] d, input logic l);
        flit_t e;
        e.src = s; e.data = d; e.last = l;
        q_rr.push_back(e);
    endtask

    task automatic drain(input bit sel_rr);
        for (int k = 0; k < 20; k++) begin
            if ((sel_rr ? q_rr.size() : q_fx.size()) == 0) break;
            tick();
        end
        chk(sel_rr ? "rr_drain_left" : "fx_drain_left", sel_rr ? q_rr.size() : q_fx.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && f_out_valid && f_out_ready) begin
            m_got = {f_out_src, f_out_data, f_out_last};
            checks++;
            if (q_fx.size() == 0) begin
                errors++;
                $display("FAIL fx_unexpected: got %0h expected none", m_got);
            end else begin
                m_fx_exp = q_fx.pop_front();
                if (m_got !== m_fx_exp) begin
                    errors++;
                    $display("FAIL fx_flit: got %0h expected %0h at %0t", m_got, m_fx_exp, $time);
                end
            end
        end
        if (!rst && a_out_valid && a_out_ready) begin
            m_got = {a_out_src, a_out_data, a_out_last};
            checks++;
            if (q_rr.size() == 0) begin
                errors++;
                $display("FAIL rr_unexpected: got %0h expected none", m_got);
            end else begin
                m_rr_exp = q_rr.pop_front();
                if (m_got !== m_rr_exp) begin
                    errors++;
                    $display("FAIL rr_flit: got %0h expected %0h at %0t", m_got, m_rr_exp, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flit_t e;
        logic [3:0] exp_rdy;
        rst         = 1'b1;
        f_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        a_in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        f_in_valid  = 4'h0;
        a_in_valid  = 4'hF;
        f_in_last   = 4'h0;
        a_in_last   = 4'hF;
        f_out_ready = 1'b1;
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_src", a_out_src, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_in_ready", a_in_ready, 0);
        a_in_valid = 4'h0;
        rst = 1'b0;
        tick();

        // fixed priority: input 0 always wins, others starve
        e.src = 2'd0; e.data = 8'h10; e.last = 1'b0;
        for (int i = 0; i < 6; i++) q_fx.push_back(e);
        f_in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fx_in_ready", f_in_ready, 4'b0001);
            tick();
        end
        f_in_valid = 4'h0;
        drain(1'b0);

        // round-robin with single-flit packets: 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) push_rr(2'(i % 4), 8'h10 + 8'((i % 4) * 17), 1'b1);
        a_in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            chk("rr_in_ready", a_in_ready, exp_rdy);
            tick();
        end
        a_in_valid = 4'h0;
        drain(1'b1);

        // packet lock on input 2 with a valid gap; input 0 must not interleave
        push_rr(2'd2, 8'hA0, 1'b0);
        push_rr(2'd2, 8'hA1, 1'b0);
        push_rr(2'd2, 8'hA2, 1'b1);
        push_rr(2'd3, 8'h33, 1'b1);
        push_rr(2'd0, 8'h05, 1'b1);
        a_in_data  = {8'h33, 8'hA0, 8'h00, 8'h05};
        a_in_last  = 4'b1001;
        a_in_valid = 4'b0101;
        #1; chk("lock_a0_rdy", a_in_ready, 4'b0100); tick();
        a_in_data[23:16] = 8'hA1;
        #1; chk("lock_a1_rdy", a_in_ready, 4'b0100); tick();
        a_in_valid = 4'b0001;
        #1; chk("lock_gap_rdy", a_in_ready, 4'b0000); tick();
        #1; chk("lock_gap2_rdy", a_in_ready, 4'b0000); tick();
        a_in_data[23:16] = 8'hA2;
        a_in_last  = 4'b1101;
        a_in_valid = 4'b0101;
        #1; chk("lock_a2_rdy", a_in_ready, 4'b0100); tick();
        a_in_valid = 4'b1001;
        #1; chk("rr_ptr3_rdy", a_in_ready, 4'b1000); tick();
        a_in_valid = 4'b0001;
        #1; chk("after_lock_rdy", a_in_ready, 4'b0001); tick();
        a_in_valid = 4'h0;
        drain(1'b1);

        // back-pressure: two flits buffered, then nothing accepted
        push_rr(2'd1, 8'h51, 1'b1);
        push_rr(2'd0, 8'h50, 1'b1);
        a_out_ready = 1'b0;
        a_in_data   = {8'h00, 8'h00, 8'h51, 8'h50};
        a_in_last   = 4'b0011;
        a_in_valid  = 4'b0011;
        #1; chk("bp_first_rdy", a_in_ready, 4'b0010); tick();
        #1; chk("bp_second_rdy", a_in_ready, 4'b0001); tick();
        #1; chk("bp_full_rdy", a_in_ready, 4'b0000);
        chk("bp_full_valid", a_out_valid, 1); tick();
        #1; chk("bp_hold_rdy", a_in_ready, 4'b0000); tick();
        a_out_ready = 1'b1;
        #1; chk("bp_pop_full_rdy", a_in_ready, 4'b0000);
        a_in_valid = 4'h0;
        tick();
        #1; chk("bp_after_pop1_valid", a_out_valid, 1); tick();
        #1; chk("bp_after_pop2_valid", a_out_valid, 0);
        drain(1'b1);

        // pointer wrap: 3 -> 0, then 0 wins over 3
        push_rr(2'd3, 8'h3C, 1'b1);
        push_rr(2'd0, 8'h0C, 1'b1);
        push_rr(2'd3, 8'h3D, 1'b1);
        a_in_data  = {8'h3C, 8'h00, 8'h00, 8'h0C};
        a_in_last  = 4'b1001;
        a_in_valid = 4'b1000;
        #1; chk("wrap_rdy3", a_in_ready, 4'b1000); tick();
        a_in_data[31:24] = 8'h3D;
        a_in_valid = 4'b1001;
        #1; chk("wrap_rdy0", a_in_ready, 4'b0001); tick();
        a_in_valid = 4'b1000;
        #1; chk("wrap_rdy3b", a_in_ready, 4'b1000); tick();
        a_in_valid = 4'h0;
        drain(1'b1);

        // reset while locked with two flits buffered; buffered flits are discarded
        a_out_ready = 1'b0;
        a_in_data   = {8'h00, 8'h00, 8'h71, 8'h00};
        a_in_last   = 4'b0000;
        a_in_valid  = 4'b0010;
        #1; chk("rm_rdy1", a_in_ready, 4'b0010); tick();
        a_in_data[15:8] = 8'h72;
        #1; chk("rm_rdy2", a_in_ready, 4'b0010); tick();
        #1; chk("rm_full_valid", a_out_valid, 1);
        rst = 1'b1;
        #1;
        chk("rm_rst_valid", a_out_valid, 0);
        chk("rm_rst_rdy", a_in_ready, 4'b0000);
        rst = 1'b0;
        push_rr(2'd0, 8'h0A, 1'b1);
        push_rr(2'd1, 8'h1A, 1'b1);
        a_out_ready = 1'b1;
        a_in_data   = {8'h00, 8'h00, 8'h1A, 8'h0A};
        a_in_last   = 4'b0011;
        a_in_valid  = 4'b0011;
        #1; chk("rm_post_rdy0", a_in_ready, 4'b0001); tick();
        a_in_valid = 4'b0010;
        #1; chk("rm_post_rdy1", a_in_ready, 4'b0010); tick();
        a_in_valid = 4'h0;
        drain(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
